// File: rtl/arith_pkg.sv
// Shared constants for the sequential arithmetic family (multiplier now, divider later).
package arith_pkg;

    localparam int ARITH_W = 4;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_FIN  = 2'd2;

    typedef enum logic [1:0] {
        IDLE = ST_IDLE,
        RUN  = ST_RUN,
        FIN  = ST_FIN
    } state_t;

endpackage

// File: rtl/mul_add_seq_if.sv
// Start/done handshake and operand/result bus of the sequential multiply-add unit.
interface mul_add_seq_if #(
    parameter int W = 4
);
    logic           start;
    logic [W-1:0]   a;
    logic [W-1:0]   b;
    logic [W-1:0]   c;
    logic           busy;
    logic           done;
    logic [2*W-1:0] p;

    modport master (
        output start, a, b, c,
        input  busy, done, p
    );

    modport slave (
        input  start, a, b, c,
        output busy, done, p
    );
endinterface

// File: rtl/mul_add_seq.sv
// Shift-add multiplier with addend: p = a*b + c, result after W+1 cycles.
module mul_add_seq
    import arith_pkg::*;
#(
    parameter int W = ARITH_W
) (
    input  logic         clk,
    input  logic         rst,
    mul_add_seq_if.slave bus
);

    localparam int CW = $clog2(W) + 1;

    state_t           state_r;
    logic [2*W-1:0]   acc_r;
    logic [2*W-1:0]   mcand_r;
    logic [W-1:0]     mplier_r;
    logic [CW-1:0]    count_r;
    logic [2*W-1:0]   p_r;
    logic             busy_r;
    logic             done_r;
    logic [2*W-1:0]   acc_next_s;

    // Accumulator value after the current iteration, also the final result on the last one.
    always_comb begin
        acc_next_s = acc_r;
        if (mplier_r[0]) begin
            acc_next_s = acc_r + mcand_r;
        end else begin
            acc_next_s = acc_r;
        end
    end

    // Control FSM and datapath registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r  <= IDLE;
            acc_r    <= {(2*W){1'b0}};
            mcand_r  <= {(2*W){1'b0}};
            mplier_r <= {W{1'b0}};
            count_r  <= {CW{1'b0}};
            p_r      <= {(2*W){1'b0}};
            busy_r   <= 1'b0;
            done_r   <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    done_r <= 1'b0;
                    if (bus.start) begin
                        acc_r    <= {{W{1'b0}}, bus.c};
                        mcand_r  <= {{W{1'b0}}, bus.a};
                        mplier_r <= bus.b;
                        count_r  <= {CW{1'b0}};
                        busy_r   <= 1'b1;
                        state_r  <= RUN;
                    end else begin
                        busy_r   <= 1'b0;
                        state_r  <= IDLE;
                    end
                end
                RUN: begin
                    acc_r    <= acc_next_s;
                    mcand_r  <= mcand_r << 1;
                    mplier_r <= mplier_r >> 1;
                    count_r  <= count_r + {{(CW-1){1'b0}}, 1'b1};
                    // Last iteration: publish the result, it holds until the next completion.
                    if (count_r == CW'(W - 1)) begin
                        p_r     <= acc_next_s;
                        done_r  <= 1'b1;
                        state_r <= FIN;
                    end else begin
                        done_r  <= 1'b0;
                        state_r <= RUN;
                    end
                end
                FIN: begin
                    done_r  <= 1'b0;
                    busy_r  <= 1'b0;
                    state_r <= IDLE;
                end
                default: begin
                    done_r  <= 1'b0;
                    busy_r  <= 1'b0;
                    state_r <= IDLE;
                end
            endcase
        end
    end

    assign bus.busy = busy_r;
    assign bus.done = done_r;
    assign bus.p    = p_r;

endmodule

// File: tb/tb_mul_add_seq.sv
// Directed self-checking bench for mul_add_seq: vector table, divider round-trip sweep, corner sequences.
module tb_mul_add_seq;

    localparam int W = 4;

    typedef struct {
        logic [W-1:0]   a;
        logic [W-1:0]   b;
        logic [W-1:0]   c;
        logic [2*W-1:0] p;
    } vec_t;

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    mul_add_seq_if #(.W(W)) bus ();

    mul_add_seq #(.W(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Called at a negedge while idle; returns at the negedge where done is seen (or the bound expires).
    task automatic run_op(input logic [W-1:0] ia, input logic [W-1:0] ib, input logic [W-1:0] ic,
                          output logic [2*W-1:0] res, output int lat);
        logic [2*W-1:0] prev_p;
        prev_p    = bus.p;
        bus.start = 1'b1;
        bus.a     = ia;
        bus.b     = ib;
        bus.c     = ic;
        @(posedge clk);
        @(negedge clk);
        bus.start = 1'b0;
        bus.a     = ~ia;
        bus.b     = ~ib;
        bus.c     = ~ic;
        check("busy_after_start", {15'd0, bus.busy}, 16'd1);
        lat = 1;
        while (bus.done !== 1'b1 && lat < 20) begin
            check("p_stable_during_run", {8'd0, bus.p}, {8'd0, prev_p});
            @(negedge clk);
            lat++;
        end
        res = bus.p;
    endtask

    vec_t vecs [8];

    initial begin
        logic [2*W-1:0] res;
        int             lat;
        int             dones;
        int             q;
        int             r;

        checks = 0;
        errors = 0;
        vecs[0] = '{a: 4'd3,  b: 4'd5,  c: 4'd2,  p: 8'h11};
        vecs[1] = '{a: 4'd3,  b: 4'd4,  c: 4'd1,  p: 8'h0D};
        vecs[2] = '{a: 4'd15, b: 4'd15, c: 4'd15, p: 8'hF0};
        vecs[3] = '{a: 4'd9,  b: 4'd0,  c: 4'd7,  p: 8'h07};
        vecs[4] = '{a: 4'd0,  b: 4'd0,  c: 4'd0,  p: 8'h00};
        vecs[5] = '{a: 4'd0,  b: 4'd7,  c: 4'd5,  p: 8'h05};
        vecs[6] = '{a: 4'd1,  b: 4'd1,  c: 4'd0,  p: 8'h01};
        vecs[7] = '{a: 4'd7,  b: 4'd9,  c: 4'd3,  p: 8'h42};

        // Reset and idle
        rst       = 1'b1;
        bus.start = 1'b0;
        bus.a     = 4'd0;
        bus.b     = 4'd0;
        bus.c     = 4'd0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check("reset_busy", {15'd0, bus.busy}, 16'd0);
            check("reset_done", {15'd0, bus.done}, 16'd0);
            check("reset_p", {8'd0, bus.p}, 16'd0);
            @(negedge clk);
        end

        // Table-driven vectors with latency and post-done checks
        for (int i = 0; i < 8; i++) begin
            run_op(vecs[i].a, vecs[i].b, vecs[i].c, res, lat);
            check("vec_latency", 16'(lat), 16'd5);
            check("vec_p", {8'd0, res}, {8'd0, vecs[i].p});
            check("vec_busy_in_fin", {15'd0, bus.busy}, 16'd1);
            @(negedge clk);
            check("vec_busy_after", {15'd0, bus.busy}, 16'd0);
            check("vec_done_after", {15'd0, bus.done}, 16'd0);
            check("vec_p_hold", {8'd0, bus.p}, {8'd0, vecs[i].p});
        end

        // Divider round-trip sweep
        for (int av = 0; av < 16; av++) begin
            for (int bv = 1; bv < 16; bv++) begin
                q = av / bv;
                r = av % bv;
                run_op(4'(q), 4'(bv), 4'(r), res, lat);
                check("roundtrip", {8'd0, res}, 16'(av));
                @(negedge clk);
            end
        end

        // Start while busy: re-assert during RUN and during FIN
        bus.start = 1'b1;
        bus.a     = 4'd2;
        bus.b     = 4'd3;
        bus.c     = 4'd1;
        @(posedge clk);
        dones = 0;
        for (int n = 1; n <= 10; n++) begin
            @(negedge clk);
            if (bus.done === 1'b1) dones++;
            if (n == 5) check("busy_start_p", {8'd0, bus.p}, 16'h0007);
            bus.start = (n == 2 || n == 5) ? 1'b1 : 1'b0;
            bus.a     = 4'd15;
            bus.b     = 4'd15;
            bus.c     = 4'd15;
            if (n >= 7) check("busy_start_no_relaunch", {15'd0, bus.busy}, 16'd0);
        end
        bus.start = 1'b0;
        check("busy_start_done_count", 16'(dones), 16'd1);
        check("busy_start_p_hold", {8'd0, bus.p}, 16'h0007);

        // Reset mid-operation
        bus.start = 1'b1;
        bus.a     = 4'd3;
        bus.b     = 4'd5;
        bus.c     = 4'd2;
        @(posedge clk);
        @(negedge clk);
        bus.start = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("midrst_busy", {15'd0, bus.busy}, 16'd0);
        check("midrst_done", {15'd0, bus.done}, 16'd0);
        check("midrst_p", {8'd0, bus.p}, 16'd0);
        repeat (6) begin
            @(negedge clk);
            check("midrst_stays_idle", {14'd0, bus.busy, bus.done}, 16'd0);
        end
        run_op(4'd3, 4'd5, 4'd2, res, lat);
        check("midrst_restart_latency", 16'(lat), 16'd5);
        check("midrst_restart_p", {8'd0, res}, 16'h0011);
        @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mul_add_seq.md
Name: mul_add_seq

Overview:
- Sequential shift-add multiplier with addend. Computes P = A*B + C over W+1 busy cycles.
- Inverse of the team's combinational divider: feeding it the divider's Q, B and R reconstructs the dividend A.
- Used as a round-trip checker and as the multiply primitive in the arithmetic library.
- Single clock domain. Start/done handshake toward the surrounding control logic.

Parameters:
- W, 4, operand width in bits; product width is 2W.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous active-high reset
- start  input  1  request; sampled only while idle
- a  input  W  multiplicand (e.g. divider quotient)
- b  input  W  multiplier (e.g. divider divisor)
- c  input  W  addend, zero-extended (e.g. divider remainder)
- busy  output  1  high whenever the FSM is not IDLE
- done  output  1  one-cycle completion pulse
- p  output  2W  result register; holds its value until the next completion

Behaviour:
- Reset:
  - rst is synchronous and has priority over all other inputs.
  - On reset: state=IDLE, busy=0, done=0, p=0, internal acc/mcand/mplier/count=0.
  - Reset asserted mid-operation aborts the operation; p is cleared, not left partial.
- States: IDLE, RUN, FIN.
- IDLE:
  - If start=1 at edge k: load acc={W'0,c}, mcand={W'0,a}, mplier=b, count=0; go to RUN.
  - Otherwise stay in IDLE.
  - a, b and c are sampled only at edge k. Later changes to them have no effect.
- RUN (edges k+1 .. k+W, exactly W iterations):
  - If mplier[0]=1: acc <= acc + mcand, using a 2W-bit adder.
  - mcand <= mcand << 1.
  - mplier <= mplier >> 1.
  - count <= count + 1.
  - On the W-th iteration (count==W-1): p <= final acc, go to FIN.
- FIN: lasts one cycle, done=1, then return to IDLE.
- done is high only in FIN, so it is first visible in the cycle after edge k+W.
- Latency: W+1 cycles from start sampled to done high.
- Throughput: one operation every W+2 cycles.
- busy = (state != IDLE). busy is high in RUN and FIN.
- start while busy (RUN or FIN) is ignored; it is neither queued nor restarts the operation.
- Width:
  - Maximum result is (2^W-1)^2 + (2^W-1) = 2^(2W) - 2^W, which fits in 2W bits.
  - No overflow is possible and none is flagged.
- b=0: p=c after the full W+1 latency; no early exit.
- a=0: same rule, p=c.
- Counter width: clog2(W)+1 bits; it never wraps within an operation.
- p changes only at the RUN->FIN edge or on reset.

Decomposition:
- Shared package arith_pkg holds:
  - state encoding constants ST_IDLE=2'd0, ST_RUN=2'd1, ST_FIN=2'd2
  - default width constant ARITH_W=4, also used by the divider family
- No sub-module: the datapath (adder, shifters) is small enough to stay inline.
- The future sequential divider reuses arith_pkg.

Test Plan:
- Reset and idle:
  - Stimulus: hold rst for 2 cycles, then release with start=0.
  - Response: busy=0, done=0, p=8'h00 throughout.
- Basic operation, a=3, b=5, c=2:
  - Stimulus: start pulse at edge k.
  - Response: busy=1 from k+1; done=1 exactly in the cycle after edge k+4; p=8'h11 (17); busy=0 after the done cycle.
- Divider round-trip:
  - Stimulus: a=3, b=4, c=1 (the quotient/divisor/remainder of 13/4).
  - Response: p=8'h0D.
  - Also sweep all A in 0..15 and B in 1..15 through the divider's outputs; p must equal A every time.
- Extremes:
  - a=15, b=15, c=15 -> p=8'hF0.
  - a=9, b=0, c=7 -> p=8'h07, still after 5 cycles.
  - a=0, b=0, c=0 -> p=0.
- Start while busy:
  - Stimulus: re-assert start with different operands during RUN and again during FIN.
  - Response: first result unaffected, exactly one done pulse, no second operation launched.
- Reset mid-operation:
  - Stimulus: assert rst at the 2nd RUN cycle.
  - Response: next cycle shows busy=0, done=0, p=0; a fresh start then completes normally with the correct result.
